stopwatch_display_scan: RTL
===========================

Name: stopwatch_display_scan

Overview:
- Downstream consumer of the stopwatch core's three 8-bit per-digit segment patterns (S0, S1, S2).
- Time-multiplexes the patterns onto one shared 8-bit segment bus with one-hot digit enables.
- Blanks the bus briefly at the start of every digit slot to suppress ghosting.
- Snapshots all three inputs once per frame so a refresh never shows a mix of old and new digits.

Parameters:
- SCAN_DIV, 1000, clock cycles per digit slot; legal range 2 or more.
- BLANK_CYCLES, 2, cycles blanked at the start of each slot; legal range 1 to SCAN_DIV-1.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- nReset  input  1  asynchronous, active-low reset.
- En  input  1  display enable; 0 forces Seg and Dig to 0.
- S0  input  8  segment pattern, digit 0; bit = 1 means segment lit.
- S1  input  8  segment pattern, digit 1.
- S2  input  8  segment pattern, digit 2.
- Seg  output  8  shared segment bus; active-high, registered.
- Dig  output  3  one-hot digit enable, bit i selects digit i; active-high, registered.
- Frame  output  1  one-cycle pulse when a new snapshot is taken; registered.

Behaviour:
- Clock and reset: one clock, Clk. Reset is asynchronous and active-low on nReset; while nReset=0 all state holds its reset value regardless of Clk.
- Reset values:
  - cnt=0, idx=0.
  - snapshot registers = 0.
  - init flag = 1.
  - Seg=8'h00, Dig=3'b000, Frame=0.
- Prescaler cnt (width clog2(SCAN_DIV)):
  - increments every edge.
  - at SCAN_DIV-1 it wraps to 0 and idx advances 0->1->2->0.
  - idx never takes the value 3.
- Snapshot: all three snapshot registers load S0/S1/S2 together on an edge where either
  - init=1 (first edge after reset release; init then clears), or
  - the pre-edge state is cnt==SCAN_DIV-1 and idx==2 (end of frame).
- Frame: set to 1 for exactly the cycle after each end-of-frame snapshot edge; 0 otherwise. It does not pulse on the init load.
- Outputs are registered from the pre-edge cnt, idx and snapshot values, so they lag the internal state by one cycle.
  - If En=0, or pre-edge cnt < BLANK_CYCLES: Seg=0 and Dig=0.
  - Otherwise: Dig = one-hot(idx) and Seg = snapshot[idx].
- En only gates the outputs: cnt, idx, snapshot and Frame keep running while En=0.
- Inputs may change on any cycle. Only values present at snapshot edges are ever displayed.
- nReset asserted mid-frame: everything returns to reset values immediately. After release, scanning restarts from digit 0 with a fresh init snapshot.
- Dig never has more than one bit set. Seg and Dig are never nonzero on the first cycle of any slot.

Test Plan (SCAN_DIV=4, BLANK_CYCLES=1; edge n = nth rising edge after nReset release)
1. Reset values: hold nReset=0, toggle Clk, drive S0..S2=8'hFF -> Seg=00, Dig=000, Frame=0 throughout; assert nReset asynchronously between edges -> outputs clear without waiting for an edge.
2. Scan order: S0=3F, S1=06, S2=5B, En=1 -> edge 1: Dig=000 (blank); edges 2-4: Dig=001, Seg=3F; edge 5: blank; edges 6-8: Dig=010, Seg=06; edge 9: blank; edges 10-12: Dig=100, Seg=5B; edges 13-16 repeat digit 0.
3. Snapshot and Frame: as scenario 2, change S1 to 66 at edge 7 -> Seg stays 06 through edge 8; Frame=1 only after edge 12 (and every 12 edges after); digit-1 slot in edges 18-20 shows 66.
4. Enable: drop En to 0 at edge 6, raise again at edge 14 -> Seg=00, Dig=000 after edges 6-14; edges 15-16: Dig=001, Seg=3F (slot timing unchanged); Frame still pulses after edge 12.
5. Mid-frame reset: pull nReset low after edge 7 for 3 cycles with S0=7F -> outputs 0 immediately; after release, edge 1 blank, edges 2-4 Dig=001, Seg=7F.
6. One-hot check: random S0..S2 and En over 500 cycles -> Dig is always 000 or exactly one bit set, and Seg=00 whenever Dig=000.

Source files
------------

// File: rtl/stopwatch_display_scan.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_display_scan
// Purpose  : Multiplexes three per-digit segment patterns onto one shared
//            segment bus with one-hot digit enables and a short blanking
//            interval at the start of each digit slot.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_display_scan #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       En,
  input  logic [7:0] S0,
  input  logic [7:0] S1,
  input  logic [7:0] S2,
  output logic [7:0] Seg,
  output logic [2:0] Dig,
  output logic       Frame
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  localparam logic [CW-1:0] c_cnt_last = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] c_blank    = CW'(BLANK_CYCLES);

  localparam logic [1:0] c_digit0 = 2'd0;
  localparam logic [1:0] c_digit1 = 2'd1;
  localparam logic [1:0] c_digit2 = 2'd2;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic          r_init;
  logic [7:0]    r_snap0;
  logic [7:0]    r_snap1;
  logic [7:0]    r_snap2;

  logic          w_cnt_wrap;
  logic          w_frame_end;
  logic          w_load;
  logic          w_blank;
  logic [CW-1:0] w_cnt_next;
  logic [1:0]    w_idx_next;
  logic [2:0]    w_dig;
  logic [7:0]    w_seg;

  assign w_cnt_wrap  = (r_cnt == c_cnt_last);
  assign w_frame_end = w_cnt_wrap && (r_idx == c_digit2);
  assign w_load      = r_init || w_frame_end;
  assign w_cnt_next  = w_cnt_wrap ? '0 : r_cnt + CW'(1);
  assign w_blank     = !En || (r_cnt < c_blank);

  always_comb begin
    w_idx_next = r_idx;
    if (w_cnt_wrap) begin
      case (r_idx)
        c_digit0: w_idx_next = c_digit1;
        c_digit1: w_idx_next = c_digit2;
        default:  w_idx_next = c_digit0;
      endcase
    end
  end

  // Digit select uses the current (pre-edge) slot; an unreachable index blanks.
  always_comb begin
    w_dig = 3'b000;
    w_seg = 8'h00;
    case (r_idx)
      c_digit0: begin w_dig = 3'b001; w_seg = r_snap0; end
      c_digit1: begin w_dig = 3'b010; w_seg = r_snap1; end
      c_digit2: begin w_dig = 3'b100; w_seg = r_snap2; end
      default:  begin w_dig = 3'b000; w_seg = 8'h00;   end
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_cnt <= '0;
      r_idx <= c_digit0;
    end else begin
      r_cnt <= w_cnt_next;
      r_idx <= w_idx_next;
    end
  end

  // All three digits load together so a frame never mixes old and new values.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_init  <= 1'b1;
      r_snap0 <= 8'h00;
      r_snap1 <= 8'h00;
      r_snap2 <= 8'h00;
    end else begin
      r_init <= 1'b0;
      if (w_load) begin
        r_snap0 <= S0;
        r_snap1 <= S1;
        r_snap2 <= S2;
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Seg   <= 8'h00;
      Dig   <= 3'b000;
      Frame <= 1'b0;
    end else begin
      Frame <= w_frame_end;
      if (w_blank) begin
        Seg <= 8'h00;
        Dig <= 3'b000;
      end else begin
        Seg <= w_seg;
        Dig <= w_dig;
      end
    end
  end

endmodule
`default_nettype wire
